irrigation_sequencer: RTL and testbench
=======================================

Name: irrigation_sequencer

Overview:
- Zone-watering controller for the residential irrigation system.
- Sequences up to N_ZONES valves through programmed watering durations in whole minutes. Counts minutes from the 1 Hz second tick supplied by the time-base counter chain.
- Drives the pump and one-hot valve outputs.
- Handles rain inhibit (pause and resume) and low-tank protection (fault).
- Exports remaining minutes and a clear strobe for the display counters.

Parameters:
N_ZONES, 4, number of valves/zones (1..8)
DUR_W, 6, width of per-zone duration in minutes (max 2^DUR_W-1)
PRIME_S, 3, seconds the pump runs with the valve open before the minute countdown starts
GAP_S, 2, seconds all valves stay closed between zones

Ports:
clk  in  1  system clock
clear  in  1  asynchronous active-low reset
sec_tick  in  1  one-clk pulse per second from time base
start  in  1  one-clk pulse: begin a cycle (ignored unless IDLE)
abort  in  1  one-clk pulse: stop immediately, return to IDLE, clear fault
rain  in  1  level, 1 = rain detected, inhibit watering
tank_low  in  1  level, 1 = reservoir below minimum
zone_en  in  N_ZONES  per-zone enable, sampled at start
dur  in  N_ZONES*DUR_W  zone i duration in minutes at bits [i*DUR_W +: DUR_W], sampled at start
valve  out  N_ZONES  one-hot (or zero) valve drive
pump  out  1  pump drive
busy  out  1  1 in any state except IDLE and FAULT
paused  out  1  1 in HOLD
done  out  1  one-clk pulse when a cycle completes normally
fault  out  1  1 in FAULT
zone_idx  out  3  index of the current zone
min_left  out  DUR_W  minutes remaining in the current zone
cnt_clear  out  1  one-clk pulse to clear the external display counters at each zone start

Behaviour:
- Reset (clear=0, asynchronous):
  - State IDLE.
  - All outputs 0; internal second counter 0; latched enables and durations 0.
- States: IDLE, SELECT, PRIME, WATER, HOLD, GAP, FAULT. All transitions occur on the clk rising edge.
- IDLE:
  - On start, latch zone_en and dur, set zone_idx=0, go to SELECT.
  - If start and abort arrive in the same cycle, abort wins and the block stays IDLE.
- SELECT:
  - Search from zone_idx upward for the first zone with en=1 and dur≠0; disabled or zero-duration zones are skipped. One zone is examined per cycle.
  - If a zone is found: set min_left=dur, clear the second counter, pulse cnt_clear, go to PRIME.
  - If zone_idx passes N_ZONES-1: pulse done, go to IDLE.
  - With no eligible zones, done fires at most N_ZONES+1 cycles after start, and valve/pump never assert.
- PRIME:
  - valve[zone_idx]=1, pump=1.
  - Count PRIME_S sec_ticks, then go to WATER.
  - Prime time does not reduce min_left.
- WATER:
  - valve[zone_idx]=1, pump=1.
  - The second counter runs 0..59 on sec_tick. On the tick where the counter is 59, it wraps to 0 and min_left decrements.
  - When min_left reaches 0 in that same cycle, go to GAP with valve=0 and pump=0 from the next cycle.
- HOLD:
  - Entered from PRIME or WATER when rain=1. valve=0, pump=0, paused=1.
  - The second counter and min_left freeze; sec_ticks are ignored.
  - When rain=0, return to PRIME: re-prime, with min_left and the second counter preserved.
- GAP:
  - valve=0, pump=0.
  - After GAP_S sec_ticks: zone_idx+1, go to SELECT.
  - rain is ignored in GAP.
- FAULT:
  - Entered from PRIME, WATER or HOLD when tank_low=1. tank_low has priority over rain in the same cycle.
  - valve=0, pump=0, fault=1, busy=0.
  - start is ignored. Only abort (or reset) exits, to IDLE.
- abort in any state:
  - Next cycle is IDLE with all outputs 0 and min_left=0.
  - Priority: abort > tank_low > rain > tick handling.
- valve is never multi-hot, and pump=1 only when some valve bit is 1 (checked by assertion).
- Inputs are synchronous to clk. sec_tick is guaranteed to be at most 1 cycle wide and at least 2 cycles apart.
- Changes to zone_en and dur during a cycle have no effect; the values are latched at start.

Test Plan:
- N_ZONES=4, zone_en=4'b0101, dur zone0=2, zone2=1; start → valve=0001 for PRIME_S+120 ticks, GAP 2 ticks, valve=0100 for 3+60 ticks, then done pulse, busy=0; cnt_clear pulsed twice.
- zone_en=4'b1111, all dur=0; start → done within 5 clks, valve and pump never 1.
- zone0 dur=3; rain=1 at the 30th second of minute 2 for 100 ticks → paused=1, valve=0, min_left holds at 2; after rain=0, 3 prime ticks then the countdown resumes; total valve-on ticks = 180 + 6.
- tank_low=1 mid-WATER → next clk valve=0, pump=0, fault=1; start ignored; abort → IDLE, fault=0.
- start and abort in the same cycle from IDLE → stays IDLE; abort mid-PRIME → all outputs 0 next cycle.
- clear asserted mid-WATER (async, between clk edges) → valve, pump and busy drop immediately; after release, state is IDLE.

Source files
------------

// File: rtl/irrigation_sequencer.sv
// Zone-watering sequencer: walks enabled zones, primes the pump, counts down whole
// minutes from the 1 Hz tick, pauses on rain and latches a fault on low tank.
module irrigation_sequencer #(
    parameter int N_ZONES = 4,
    parameter int DUR_W   = 6,
    parameter int PRIME_S = 3,
    parameter int GAP_S   = 2
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic                     sec_tick,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     rain,
    input  logic                     tank_low,
    input  logic [N_ZONES-1:0]       zone_en,
    input  logic [N_ZONES*DUR_W-1:0] dur,
    output logic [N_ZONES-1:0]       valve,
    output logic                     pump,
    output logic                     busy,
    output logic                     paused,
    output logic                     done,
    output logic                     fault,
    output logic [2:0]               zone_idx,
    output logic [DUR_W-1:0]         min_left,
    output logic                     cnt_clear
);

    typedef enum logic [2:0] {IDLE, SELECT, PRIME, WATER, HOLD, GAP, FAULT} state_t;

    localparam int PH_MAX = (PRIME_S > GAP_S) ? PRIME_S : GAP_S;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    state_t                   state;
    logic [N_ZONES-1:0]       en_q;
    logic [N_ZONES*DUR_W-1:0] dur_q;
    // One bit wider than the output so the search can step past zone N_ZONES-1.
    logic [3:0]               zidx;
    logic [5:0]               sec_cnt;
    logic [PH_W-1:0]          ph_cnt;

    logic [DUR_W-1:0]         cur_dur;
    logic                     cur_ok;
    logic [N_ZONES-1:0]       cur_hot;

    assign zone_idx = zidx[2:0];

    always_comb begin
        cur_dur = '0;
        cur_ok  = 1'b0;
        cur_hot = '0;
        for (int i = 0; i < N_ZONES; i++) begin
            if (zidx == 4'(i)) begin
                cur_dur    = dur_q[i*DUR_W +: DUR_W];
                cur_ok     = en_q[i] && (dur_q[i*DUR_W +: DUR_W] != '0);
                cur_hot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state     <= IDLE;
            en_q      <= '0;
            dur_q     <= '0;
            zidx      <= '0;
            sec_cnt   <= '0;
            ph_cnt    <= '0;
            valve     <= '0;
            pump      <= 1'b0;
            busy      <= 1'b0;
            paused    <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            min_left  <= '0;
            cnt_clear <= 1'b0;
        end else begin
            done      <= 1'b0;
            cnt_clear <= 1'b0;
            if (abort) begin
                state    <= IDLE;
                zidx     <= '0;
                sec_cnt  <= '0;
                ph_cnt   <= '0;
                valve    <= '0;
                pump     <= 1'b0;
                busy     <= 1'b0;
                paused   <= 1'b0;
                fault    <= 1'b0;
                min_left <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            en_q  <= zone_en;
                            dur_q <= dur;
                            zidx  <= '0;
                            busy  <= 1'b1;
                            state <= SELECT;
                        end
                    end
                    SELECT: begin
                        if (zidx >= 4'(N_ZONES)) begin
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            zidx     <= '0;
                            min_left <= '0;
                            state    <= IDLE;
                        end else if (cur_ok) begin
                            min_left  <= cur_dur;
                            sec_cnt   <= '0;
                            ph_cnt    <= '0;
                            cnt_clear <= 1'b1;
                            valve     <= cur_hot;
                            pump      <= 1'b1;
                            state     <= PRIME;
                        end else begin
                            zidx <= zidx + 4'd1;
                        end
                    end
                    PRIME, WATER: begin
                        if (tank_low) begin
                            valve <= '0;
                            pump  <= 1'b0;
                            busy  <= 1'b0;
                            fault <= 1'b1;
                            state <= FAULT;
                        end else if (rain) begin
                            valve  <= '0;
                            pump   <= 1'b0;
                            paused <= 1'b1;
                            state  <= HOLD;
                        end else if (sec_tick) begin
                            if (state == PRIME) begin
                                if (ph_cnt == PH_W'(PRIME_S - 1)) begin
                                    ph_cnt <= '0;
                                    state  <= WATER;
                                end else begin
                                    ph_cnt <= ph_cnt + 1'b1;
                                end
                            end else if (sec_cnt == 6'd59) begin
                                sec_cnt  <= '0;
                                min_left <= min_left - 1'b1;
                                if (min_left == DUR_W'(1)) begin
                                    valve  <= '0;
                                    pump   <= 1'b0;
                                    ph_cnt <= '0;
                                    state  <= GAP;
                                end
                            end else begin
                                sec_cnt <= sec_cnt + 6'd1;
                            end
                        end
                    end
                    HOLD: begin
                        if (tank_low) begin
                            paused <= 1'b0;
                            busy   <= 1'b0;
                            fault  <= 1'b1;
                            state  <= FAULT;
                        end else if (!rain) begin
                            // Re-prime after rain; the minute position is kept.
                            paused <= 1'b0;
                            valve  <= cur_hot;
                            pump   <= 1'b1;
                            ph_cnt <= '0;
                            state  <= PRIME;
                        end
                    end
                    GAP: begin
                        if (sec_tick) begin
                            if (ph_cnt == PH_W'(GAP_S - 1)) begin
                                ph_cnt <= '0;
                                zidx   <= zidx + 4'd1;
                                state  <= SELECT;
                            end else begin
                                ph_cnt <= ph_cnt + 1'b1;
                            end
                        end
                    end
                    FAULT: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    a_valve_safe: assert property (@(posedge clk) disable iff (!clear)
        $onehot0(valve) && (!pump || (|valve)));

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Scoreboard bench for irrigation_sequencer: stimulus queues expected events,
// a negedge monitor pops and compares as the DUT presents them.
module tb_irrigation_sequencer;
    localparam int N  = 4;
    localparam int DW = 6;
    localparam logic [39:0] ALL_ZERO = '0;

    logic clk = 1'b0, clear = 1'b0, sec_tick = 1'b0, start = 1'b0, abort = 1'b0;
    logic rain = 1'b0, tank_low = 1'b0;
    logic [N-1:0]    zone_en = '0;
    logic [N*DW-1:0] dur = '0;
    logic [N-1:0]    valve;
    logic            pump, busy, paused, done, fault, cnt_clear;
    logic [2:0]      zone_idx;
    logic [DW-1:0]   min_left;

    irrigation_sequencer #(.N_ZONES(N), .DUR_W(DW), .PRIME_S(3), .GAP_S(2)) dut (
        .clk(clk), .clear(clear), .sec_tick(sec_tick), .start(start), .abort(abort),
        .rain(rain), .tank_low(tank_low), .zone_en(zone_en), .dur(dur),
        .valve(valve), .pump(pump), .busy(busy), .paused(paused), .done(done),
        .fault(fault), .zone_idx(zone_idx), .min_left(min_left), .cnt_clear(cnt_clear)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {K_CLR, K_DONE, K_FAULT, K_SNAP} kind_t;
    typedef struct {
        kind_t       kind;
        string       name;
        logic [39:0] exp;
    } item_t;

    item_t       sbq[$];
    int          n_vec = 0, n_bad = 0, done_cnt = 0;
    int          on_ticks[N];
    logic        any_on = 1'b0, fault_d = 1'b0, probe = 1'b0;
    logic [31:0] ot;

    task automatic compare(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic pop_cmp(input kind_t k, input logic [39:0] act);
        item_t it;
        if (sbq.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_%s: got %0h, expected no event", k.name(), act);
            return;
        end
        it = sbq.pop_front();
        if (it.kind != k) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: got %s event, expected %s event", it.name, k.name(), it.kind.name());
        end else begin
            compare(it.name, act, it.exp);
        end
    endtask

    // Monitor: tallies valve-on seconds per zone since the last accepted start.
    always @(negedge clk) begin
        if (start && !busy && !fault) begin
            for (int i = 0; i < N; i++) on_ticks[i] = 0;
            any_on = 1'b0;
        end else begin
            if ((|valve) || pump) any_on = 1'b1;
            for (int i = 0; i < N; i++) if (sec_tick && valve[i]) on_ticks[i]++;
        end
        if (fault && !fault_d) pop_cmp(K_FAULT, {32'b0, valve, pump, fault, busy, paused});
        fault_d = fault;
        if (cnt_clear) pop_cmp(K_CLR, {31'b0, zone_idx, min_left});
        if (done) begin
            for (int i = 0; i < N; i++) ot[i*8 +: 8] = on_ticks[i][7:0];
            pop_cmp(K_DONE, {7'b0, any_on, ot});
            done_cnt++;
        end
        if (probe)
            pop_cmp(K_SNAP, {21'b0, valve, pump, busy, paused, done, fault, cnt_clear,
                             zone_idx, min_left});
    end

    function automatic logic [39:0] snapv(logic [3:0] v, logic p, logic b, logic ps,
                                          logic f, logic [2:0] z, logic [5:0] m);
        return {21'b0, v, p, b, ps, 1'b0, f, 1'b0, z, m};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        cyc(1);
        sec_tick = 1'b0;
        cyc(1);
    endtask

    task automatic expect_ev(input kind_t k, input string nm, input logic [39:0] e);
        sbq.push_back('{k, nm, e});
    endtask

    task automatic snap(input string nm, input logic [39:0] e);
        expect_ev(K_SNAP, nm, e);
        probe = 1'b1;
        cyc(1);
        probe = 1'b0;
    endtask

    task automatic go(input logic [3:0] en, input logic [23:0] d);
        zone_en = en;
        dur     = d;
        start   = 1'b1;
        cyc(1);
        start   = 1'b0;
    endtask

    task automatic tick_until_done(input string nm, input int max);
        int d0 = done_cnt;
        int k  = 0;
        while (done_cnt == d0 && k < max) begin
            tick();
            k++;
        end
        if (done_cnt == d0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_timeout: got no done after %0d ticks, expected done", nm, max);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        // Reset
        repeat (2) @(posedge clk);
        #1;
        snap("reset_state", ALL_ZERO);
        clear = 1'b1;
        cyc(1);
        snap("idle_after_reset", ALL_ZERO);

        // Two enabled zones with a disabled zone between them
        expect_ev(K_CLR, "t1_clr_z0", {31'b0, 3'd0, 6'd2});
        go(4'b0101, {6'd0, 6'd1, 6'd0, 6'd2});
        repeat (10) tick();
        snap("t1_water_z0", snapv(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 6'd2));
        expect_ev(K_CLR, "t1_clr_z2", {31'b0, 3'd2, 6'd1});
        expect_ev(K_DONE, "t1_done_valve_ticks", {7'b0, 1'b1, 8'd0, 8'd63, 8'd0, 8'd123});
        tick_until_done("t1", 400);
        cyc(1);
        snap("t1_idle_after_done", ALL_ZERO);

        // All zones zero duration
        expect_ev(K_DONE, "t2_done_no_water", {7'b0, 1'b0, 32'b0});
        zone_en = 4'b1111;
        dur     = '0;
        start   = 1'b1;
        cyc(1);
        start   = 1'b0;
        lat     = 0;
        while (!done && lat < 20) begin
            cyc(1);
            lat++;
        end
        n_vec++;
        if (lat > N + 1) begin
            n_bad++;
            $display("FAIL t2_latency: got %0d cycles, expected at most %0d", lat, N + 1);
        end
        cyc(2);

        // Rain pause in the second minute, then resume
        expect_ev(K_CLR, "t3_clr", {31'b0, 3'd0, 6'd3});
        go(4'b0001, {18'b0, 6'd3});
        cyc(1);
        repeat (93) tick();
        rain = 1'b1;
        cyc(1);
        repeat (100) tick();
        snap("t3_hold", snapv(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 6'd2));
        rain = 1'b0;
        cyc(1);
        snap("t3_reprime", snapv(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 6'd2));
        expect_ev(K_DONE, "t3_done_valve_ticks", {7'b0, 1'b1, 24'b0, 8'd186});
        tick_until_done("t3", 300);
        cyc(2);

        // Low tank during watering
        expect_ev(K_CLR, "t4_clr", {31'b0, 3'd0, 6'd5});
        go(4'b0001, {18'b0, 6'd5});
        cyc(1);
        repeat (5) tick();
        expect_ev(K_FAULT, "t4_fault_entry", {32'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0});
        tank_low = 1'b1;
        cyc(1);
        snap("t4_fault_state", snapv(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 6'd5));
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        snap("t4_start_ignored", snapv(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 6'd5));
        abort = 1'b1;
        cyc(1);
        abort    = 1'b0;
        tank_low = 1'b0;
        snap("t4_abort_clears", ALL_ZERO);

        // Start with abort, then abort during prime
        zone_en = 4'b0001;
        dur     = {18'b0, 6'd1};
        start   = 1'b1;
        abort   = 1'b1;
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
        snap("t5_start_abort", ALL_ZERO);
        cyc(2);
        snap("t5_still_idle", ALL_ZERO);
        expect_ev(K_CLR, "t5_clr", {31'b0, 3'd0, 6'd1});
        go(4'b0001, {18'b0, 6'd1});
        cyc(1);
        tick();
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        snap("t5_abort_prime", ALL_ZERO);

        // Asynchronous reset mid-watering
        expect_ev(K_CLR, "t6_clr", {31'b0, 3'd0, 6'd2});
        go(4'b0001, {18'b0, 6'd2});
        cyc(1);
        repeat (5) tick();
        snap("t6_water", snapv(4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 6'd2));
        #1 clear = 1'b0;
        snap("t6_async_clear", ALL_ZERO);
        clear = 1'b1;
        cyc(1);
        snap("t6_idle_after_clear", ALL_ZERO);

        cyc(5);
        n_vec++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_expectations: got %0d pending, expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
